mem_lsu: RTL and testbench

Load/store unit between the CPU execute stage and a word-addressed memory port (SPRAM, block RAM or simulation RAM). It accepts one byte, halfword or word access at a time and drives the memory port. For stores it generates the byte write mask and lane-replicated write data. For loads it extracts and sign- or zero-extends the addressed lane. It reports misalignment and memory timeouts as faults instead of hanging the core.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/lsu_align.sv | 61 ++++++
 rtl/mem_lsu.sv | 164 ++++++++++++++++
 tb/tb_mem_lsu.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types for the load/store unit: access-size encoding,
//                FSM state encoding and the timeout-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access size as carried on req_size; encoding 2'd3 is the illegal size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Wait counter is at least 8 bits so small timeouts keep a familiar width.
  function automatic int unsigned lsu_cnt_width(input int unsigned t);
    return (t < 256) ? 8 : $clog2(t + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane logic for the load/store unit.
//                Ports: i_size / i_addr_lo / i_unsigned describe the access,
//                i_wdata is right-aligned store data, i_mem_rdata the memory
//                word; o_misalign flags alignment or illegal-size faults,
//                o_wmask / o_wdata are the store byte enables and replicated
//                data, o_rdata the extended load result.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_misalign,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_mem_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_mem_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_misalign = 1'b0;
    o_wmask    = 4'b0000;
    o_wdata    = i_wdata;
    o_rdata    = 32'h0;
    case (i_size)
      SZ_BYTE: begin
        o_wmask = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      end
      SZ_HALF: begin
        o_misalign = i_addr_lo[0];
        o_wmask    = 4'b0011 << i_addr_lo;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {{16{w_half[15] & ~i_unsigned}}, w_half};
      end
      SZ_WORD: begin
        o_misalign = |i_addr_lo;
        o_wmask    = 4'b1111;
        o_rdata    = i_mem_rdata;
      end
      default: begin
        o_misalign = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu
//  Description : Load/store unit between the execute stage and a
//                word-addressed memory port. One access in flight at a time.
//                Ports: i_req_* CPU request (valid/we/size/unsigned/addr/
//                wdata) with o_req_ready; o_resp_* one-cycle response with
//                load data and misaligned/timeout fault flags; o_mem_* memory
//                address, data, mask and strobes; i_mem_rdata / i_mem_done
//                memory return path.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_misaligned,
  output logic        o_resp_timeout,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wmask,
  output logic        o_mem_wen,
  output logic        o_mem_ren,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_done
);

  localparam int unsigned CW = lsu_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] C_TMO = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_RESP  = RESP;

  logic [1:0]    r_state;
  logic          r_we;
  logic [1:0]    r_size;
  logic [1:0]    r_lo;
  logic          r_uns;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_wmask;
  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_mis;
  logic          r_resp_to;

  logic          w_idle;
  logic [1:0]    w_size;
  logic [1:0]    w_lo;
  logic          w_misalign;
  logic [3:0]    w_st_mask;
  logic [31:0]   w_st_data;
  logic [31:0]   w_ld_data;
  logic [CW-1:0] w_cnt_next;

  // In IDLE the aligner decodes the incoming request; afterwards it decodes
  // the captured access so the load lane can be picked from i_mem_rdata.
  assign w_idle     = (r_state == S_IDLE);
  assign w_size     = w_idle ? i_req_size : r_size;
  assign w_lo       = w_idle ? i_req_addr[1:0] : r_lo;
  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  lsu_align u_align (
    .i_size      (w_size),
    .i_addr_lo   (w_lo),
    .i_unsigned  (r_uns),
    .i_wdata     (i_req_wdata),
    .i_mem_rdata (i_mem_rdata),
    .o_misalign  (w_misalign),
    .o_wmask     (w_st_mask),
    .o_wdata     (w_st_data),
    .o_rdata     (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_lo         <= 2'b00;
      r_uns        <= 1'b0;
      r_cnt        <= '0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_wmask  <= 4'h0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_mis   <= 1'b0;
      r_resp_to    <= 1'b0;
    end else begin
      // Response fields are zero whenever no response is being presented.
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_mis   <= 1'b0;
      r_resp_to    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we   <= i_req_we;
            r_size <= i_req_size;
            r_lo   <= i_req_addr[1:0];
            r_uns  <= i_req_unsigned;
            if (w_misalign) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_mis   <= 1'b1;
            end else begin
              r_state     <= S_ISSUE;
              r_cnt       <= '0;
              r_mem_addr  <= {i_req_addr[31:2], 2'b00};
              r_mem_wdata <= i_req_we ? w_st_data : 32'h0;
              r_mem_wmask <= i_req_we ? w_st_mask : 4'h0;
            end
          end
        end
        // A done seen here may be stale from the previous transaction.
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (i_mem_done || (w_cnt_next >= C_TMO)) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_to    <= ~i_mem_done;
            r_resp_rdata <= (i_mem_done && !r_we) ? w_ld_data : 32'h0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_wmask  <= 4'h0;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready       = w_idle;
  assign o_mem_wen         = (r_state == S_ISSUE) & r_we;
  assign o_mem_ren         = (r_state == S_ISSUE) & ~r_we;
  assign o_mem_addr        = r_mem_addr;
  assign o_mem_wdata       = r_mem_wdata;
  assign o_mem_wmask       = r_mem_wmask;
  assign o_resp_valid      = r_resp_valid;
  assign o_resp_rdata      = r_resp_rdata;
  assign o_resp_misaligned = r_resp_mis;
  assign o_resp_timeout    = r_resp_to;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_lsu
//  Description : Self-checking bench for mem_lsu with a short timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'b00;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_addr = 32'h0;
  logic [31:0] i_req_wdata = 32'h0;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_misaligned;
  logic        o_resp_timeout;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        o_mem_wen;
  logic        o_mem_ren;
  logic [31:0] i_mem_rdata = 32'h0;
  logic        i_mem_done = 1'b0;

  mem_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_req_valid       (i_req_valid),
    .o_req_ready       (o_req_ready),
    .i_req_we          (i_req_we),
    .i_req_size        (i_req_size),
    .i_req_unsigned    (i_req_unsigned),
    .i_req_addr        (i_req_addr),
    .i_req_wdata       (i_req_wdata),
    .o_resp_valid      (o_resp_valid),
    .o_resp_rdata      (o_resp_rdata),
    .o_resp_misaligned (o_resp_misaligned),
    .o_resp_timeout    (o_resp_timeout),
    .o_mem_addr        (o_mem_addr),
    .o_mem_wdata       (o_mem_wdata),
    .o_mem_wmask       (o_mem_wmask),
    .o_mem_wen         (o_mem_wen),
    .o_mem_ren         (o_mem_ren),
    .i_mem_rdata       (i_mem_rdata),
    .i_mem_done        (i_mem_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  // Expected timeline of the current transaction (cycle numbers absolute).
  int          t_acc  = -100;
  int          t_resp = -100;
  logic        t_we = 1'b0, t_mis = 1'b0, t_to = 1'b0;
  logic [31:0] t_addr = 32'h0, t_wdata = 32'h0, t_rdata = 32'h0;
  logic [3:0]  t_wmask = 4'h0;

  // Observations used by the literal checks of directed cases.
  logic [31:0] seen_addr, seen_wdata, seen_rdata;
  logic [3:0]  seen_wmask;
  logic        seen_wen, seen_mis, seen_to;
  int          seen_strobes = 0;
  int          seen_rel = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (from the access rules) ----------------
  function automatic logic f_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    return (int'(a[1:0]) % (1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] f_mask(input logic [1:0] sz, input logic [31:0] a);
    int nb = 1 << sz;
    logic [3:0] m = 4'((1 << nb) - 1);
    return m << a[1:0];
  endfunction

  function automatic logic [31:0] f_rep(input logic [1:0] sz, input logic [31:0] wd);
    int nb = 1 << sz;
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] word);
    int bits = 8 * (1 << sz);
    logic [31:0] v = word >> (8 * a[1:0]);
    logic [31:0] keep;
    if (bits < 32) begin
      keep = (32'h1 << bits) - 32'h1;
      v = v & keep;
      if (!uns && v[bits-1]) v = v | ~keep;
    end
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (run && !rst) begin
      bit busy;
      busy = (cyc > t_acc) && (cyc <= t_resp);
      chk("req_ready", {31'b0, o_req_ready}, {31'b0, !busy});
      chk("mem_wen", {31'b0, o_mem_wen}, {31'b0, !t_mis && t_we && cyc == t_acc + 1});
      chk("mem_ren", {31'b0, o_mem_ren}, {31'b0, !t_mis && !t_we && cyc == t_acc + 1});
      if (!t_mis && cyc >= t_acc + 1 && cyc < t_resp) begin
        chk("mem_addr", o_mem_addr, t_addr);
        chk("mem_wmask", {28'b0, o_mem_wmask}, {28'b0, t_wmask});
        if (t_we) chk("mem_wdata", o_mem_wdata, t_wdata);
      end
      chk("resp_valid", {31'b0, o_resp_valid}, {31'b0, cyc == t_resp});
      if (cyc == t_resp) begin
        chk("resp_rdata", o_resp_rdata, t_rdata);
        chk("resp_misaligned", {31'b0, o_resp_misaligned}, {31'b0, t_mis});
        chk("resp_timeout", {31'b0, o_resp_timeout}, {31'b0, t_to});
      end else begin
        chk("idle_rdata", o_resp_rdata, 32'h0);
        chk("idle_flags", {30'b0, o_resp_misaligned, o_resp_timeout}, 32'h0);
      end
      if (cyc == t_acc + 1) begin
        seen_addr  = o_mem_addr;
        seen_wdata = o_mem_wdata;
        seen_wmask = o_mem_wmask;
        seen_wen   = o_mem_wen;
      end
      if (o_mem_ren || o_mem_wen) seen_strobes++;
      if (o_resp_valid) begin
        seen_rel   = cyc - t_acc;
        seen_rdata = o_resp_rdata;
        seen_mis   = o_resp_misaligned;
        seen_to    = o_resp_timeout;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic scramble_req();
    i_req_valid    = 1'b0;
    i_req_we       = 1'($urandom);
    i_req_size     = 2'($urandom);
    i_req_unsigned = 1'($urandom);
    i_req_addr     = $urandom;
    i_req_wdata    = $urandom;
    i_mem_rdata    = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      scramble_req();
      i_mem_done = 1'($urandom);
    end
  endtask

  // k: WAIT-cycle index (1-based) in which mem_done is raised; k > T times out.
  task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] word, input int k, input logic stale);
    int acc;
    @(posedge clk); #1;
    acc = cyc;
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_size     = sz;
    i_req_unsigned = uns;
    i_req_addr     = a;
    i_req_wdata    = wd;
    i_mem_done     = 1'($urandom);
    i_mem_rdata    = $urandom;
    seen_strobes   = 0;
    seen_rel       = -1;
    t_acc   = acc;
    t_we    = we;
    t_mis   = f_mis(sz, a);
    t_to    = !t_mis && (k > T);
    t_resp  = t_mis ? acc + 1 : ((k <= T) ? acc + 2 + k : acc + 2 + T);
    t_addr  = {a[31:2], 2'b00};
    t_wmask = (we && !t_mis) ? f_mask(sz, a) : 4'h0;
    t_wdata = t_mis ? 32'h0 : f_rep(sz, wd);
    t_rdata = (t_mis || t_to || we) ? 32'h0 : f_load(sz, uns, a, word);
    for (int c = acc + 1; c <= t_resp; c++) begin
      @(posedge clk); #1;
      scramble_req();
      if (c == acc + 1 && !t_mis) i_mem_done = stale;
      else if (c == t_resp)       i_mem_done = 1'($urandom);
      else begin
        i_mem_done = (c == acc + 1 + k);
        if (c == acc + 1 + k) i_mem_rdata = word;
      end
    end
    @(negedge clk); #1;
  endtask

  initial begin
    int acc;
    logic [1:0] sz;
    int k;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, o_req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, o_resp_valid}, 32'h0);
    chk("rst_strobes", {30'b0, o_mem_ren, o_mem_wen}, 32'h0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    rst = 1'b0;
    run = 1'b1;

    // Store byte 0xA5 to 0x10000003, 1-cycle memory
    do_txn(1'b1, 2'd0, 1'b0, 32'h1000_0003, 32'h1234_56A5, 32'h0, 1, 1'b0);
    chk("sb_addr", seen_addr, 32'h1000_0000);
    chk("sb_wmask", {28'b0, seen_wmask}, 32'h8);
    chk("sb_wdata", seen_wdata, 32'hA5A5_A5A5);
    chk("sb_wen", {31'b0, seen_wen}, 32'h1);
    chk("sb_strobes", seen_strobes, 1);
    chk("sb_latency", seen_rel, 3);
    chk("sb_rdata", seen_rdata, 32'h0);

    // Loads from 0x10000002 with word 0x80FF1234
    do_txn(1'b0, 2'd1, 1'b0, 32'h1000_0002, 32'h0, 32'h80FF_1234, 1, 1'b0);
    chk("lh_rdata", seen_rdata, 32'hFFFF_80FF);
    chk("lh_latency", seen_rel, 3);
    do_txn(1'b0, 2'd1, 1'b1, 32'h1000_0002, 32'h0, 32'h80FF_1234, 2, 1'b0);
    chk("lhu_rdata", seen_rdata, 32'h0000_80FF);
    chk("lhu_latency", seen_rel, 4);
    do_txn(1'b0, 2'd0, 1'b0, 32'h1000_0002, 32'h0, 32'h80FF_1234, 1, 1'b0);
    chk("lb_rdata", seen_rdata, 32'hFFFF_FFFF);

    // Misaligned word and half
    do_txn(1'b0, 2'd2, 1'b0, 32'h1000_0002, 32'h0, 32'h0, 1, 1'b0);
    chk("mis_w_flag", {31'b0, seen_mis}, 32'h1);
    chk("mis_w_latency", seen_rel, 1);
    chk("mis_w_strobes", seen_strobes, 0);
    chk("mis_w_rdata", seen_rdata, 32'h0);
    do_txn(1'b1, 2'd1, 1'b0, 32'h1000_0001, 32'hFFFF_FFFF, 32'h0, 1, 1'b0);
    chk("mis_h_flag", {31'b0, seen_mis}, 32'h1);
    chk("mis_h_strobes", seen_strobes, 0);

    // Done stale-high during ISSUE is ignored
    do_txn(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 1, 1'b1);
    chk("stale_latency", seen_rel, 3);
    chk("stale_rdata", seen_rdata, 32'hDEAD_BEEF);

    // Timeout with done held low
    do_txn(1'b0, 2'd2, 1'b0, 32'h1000_0008, 32'h0, 32'h0, 50, 1'b0);
    chk("to_flag", {31'b0, seen_to}, 32'h1);
    chk("to_latency", seen_rel, 6);
    chk("to_rdata", seen_rdata, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      idle($urandom_range(0, 2));
      sz = 2'($urandom);
      k  = $urandom_range(1, T + 2);
      do_txn(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom, k, 1'($urandom));
    end

    // Reset mid-WAIT, then a late done must not produce a response
    @(posedge clk); #1;
    acc = cyc;
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_size = 2'd2; i_req_unsigned = 1'b0;
    i_req_addr = 32'h2000_0000; i_mem_done = 1'b0;
    t_acc = acc; t_we = 1'b0; t_mis = 1'b0; t_to = 1'b1; t_resp = acc + 2 + T;
    t_addr = 32'h2000_0000; t_wmask = 4'h0; t_wdata = 32'h0; t_rdata = 32'h0;
    @(posedge clk); #1;
    scramble_req(); i_mem_done = 1'b0;
    @(posedge clk); #1;
    scramble_req(); i_mem_done = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("wrst_ready", {31'b0, o_req_ready}, 32'h1);
    chk("wrst_strobes", {30'b0, o_mem_ren, o_mem_wen}, 32'h0);
    chk("wrst_mem_addr", o_mem_addr, 32'h0);
    chk("wrst_resp", {29'b0, o_resp_valid, o_resp_misaligned, o_resp_timeout}, 32'h0);
    t_acc = -100;
    t_resp = -100;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    i_mem_done = 1'b1;
    @(posedge clk); #1;
    i_mem_done = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
